// File: rtl/priority_encoder_pipe.sv
// rtl/priority_encoder_pipe.sv - priority/one-hot encoder feeding a 2-entry result FIFO
module priority_encoder_pipe #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] encode_in,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] encode_out,
    output logic             out_zero,
    output logic             out_multi,
    output logic [7:0]       err_count
);

    localparam int ENTRY_W = OUT_W + 2;

    logic [OUT_W-1:0]   lo_idx;
    logic [OUT_W-1:0]   hi_idx;
    logic [OUT_W-1:0]   enc_idx;
    logic               enc_zero;
    logic               enc_multi;
    logic [ENTRY_W-1:0] mem [2];
    logic [ENTRY_W-1:0] head;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (encode_in[i]) lo_idx = OUT_W'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (encode_in[i]) hi_idx = OUT_W'(i);
        end
        enc_zero  = ~|encode_in;
        // Clearing the lowest set bit leaves something only when two or more were set.
        enc_multi = |(encode_in & (encode_in - WIDTH'(1)));
        case (MODE)
            1:       enc_idx = lo_idx;
            2:       enc_idx = hi_idx;
            default: enc_idx = (!enc_zero && !enc_multi) ? lo_idx : '0;
        endcase
    end

    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enc_idx, enc_zero, enc_multi};
    end

    assign head       = mem[rd_ptr];
    assign encode_out = out_valid ? head[ENTRY_W-1:2] : '0;
    assign out_zero   = out_valid ? head[1] : 1'b0;
    assign out_multi  = out_valid ? head[0] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= 8'd0;
        end else if (push && (enc_zero || enc_multi) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
